// File: rtl/io_pwr_seq.sv
// io_pwr_seq: power sequencer for one IO-ring supply segment (switch, settle, isolation, pad enable).
// Define IO_PWR_SEQ_TIMEOUT_EN to add a power-good timeout that raises the sticky err_o flag.
module io_pwr_seq #(
    parameter int SETTLE_CYC  = 16,
    parameter int ISO_CYC     = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwr_req_i,
    output logic pwr_ack_o,
    output logic busy_o,
    input  logic vdd_pg_i,
    output logic vdd_sw_en_o,
    output logic iso_en_o,
    output logic pad_oe_en_o,
    output logic err_o
);
`ifdef IO_PWR_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = (TO_EN && TO_W > CNT_W) ? TO_W : CNT_W;

    typedef enum logic [2:0] {OFF, WAIT_PG, SETTLE, ISO_REL, ON, ISO_SET, SW_OFF} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_q, lock_d, err_q, err_d;
    logic                   sw_q, iso_q, oe_q, ack_q, busy_q;
    logic                   pg_s;

    assign pg_s        = sync_q[SYNC_STAGES-1];
    assign vdd_sw_en_o = sw_q;
    assign iso_en_o    = iso_q;
    assign pad_oe_en_o = oe_q;
    assign pwr_ack_o   = ack_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        lock_d  = lock_q;
        err_d   = err_q;
        case (state_q)
            OFF: begin
                lock_d = lock_q && pwr_req_i;
                if (pwr_req_i && !lock_q) begin
                    state_d = WAIT_PG;
                    cnt_d   = '0;
                end
            end
            WAIT_PG: begin
                if (!pwr_req_i) state_d = SW_OFF;
                else if (pg_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (TO_EN && cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = SW_OFF;
                    lock_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            SETTLE: begin
                if (!pg_s || !pwr_req_i) state_d = SW_OFF;
                else if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    state_d = ISO_REL;
                    cnt_d   = '0;
                end
            end
            ISO_REL: begin
                if (!pg_s || !pwr_req_i) begin
                    state_d = ISO_SET;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(ISO_CYC - 1)) state_d = ON;
            end
            ON: begin
                // power loss outranks a simultaneous request drop so the lock is never missed
                if (!pg_s) begin
                    state_d = ISO_SET;
                    cnt_d   = '0;
                    lock_d  = 1'b1;
                    err_d   = err_q | TO_EN;
                end else if (!pwr_req_i) begin
                    state_d = ISO_SET;
                    cnt_d   = '0;
                end
            end
            ISO_SET: state_d = (cnt_q == CW'(ISO_CYC - 1)) ? SW_OFF : ISO_SET;
            SW_OFF:  state_d = pg_s ? SW_OFF : OFF;
            default: state_d = OFF;
        endcase
        if (state_d == OFF && !pwr_req_i) err_d = 1'b0;
    end

    // outputs are registered from the next state so they change on the transition edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            cnt_q   <= '0;
            sync_q  <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            sw_q    <= 1'b0;
            iso_q   <= 1'b1;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], vdd_pg_i};
            lock_q  <= lock_d;
            err_q   <= err_d;
            sw_q    <= !(state_d inside {OFF, SW_OFF});
            iso_q   <= !(state_d inside {ISO_REL, ON});
            oe_q    <= state_d == ON;
            ack_q   <= state_d == ON;
            busy_q  <= !(state_d inside {OFF, ON});
        end
    end
endmodule
